register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// CPU-visible register bank: read-only inputs, byte-enabled RW registers and a W1C
// interrupt block, with single-cycle registered reads.
module register_bank_rwreg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  ipClk,
    input  logic                  Reset,
    input  logic                  ipWe,
    input  logic [DATA_WIDTH-1:0] ipWrData,
    input  logic [DATA_WIDTH-1:0] ipMask,
    output logic [DATA_WIDTH-1:0] opData,
    output logic                  opStrobe
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_strobe;

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_data   <= RST_VAL;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= ipWe;
            if (ipWe)
                r_data <= (r_data & ~ipMask) | (ipWrData & ipMask);
        end
    end

    assign opData   = r_data;
    assign opStrobe = r_strobe;
endmodule

module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RO     = 4,
    parameter int NUM_RW     = 4,
    parameter int NUM_IRQ    = 8,
    parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET = '0
) (
    input  logic                         ipClk,
    input  logic                         Reset,
    input  logic [ADDR_WIDTH-1:0]        ipAddress,
    input  logic [DATA_WIDTH-1:0]        ipWrData,
    input  logic [DATA_WIDTH/8-1:0]      ipByteEnable,
    input  logic                         ipWrEnable,
    input  logic                         ipRdEnable,
    output logic [DATA_WIDTH-1:0]        opRdData,
    output logic                         opRdValid,
    output logic                         opRdError,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ipRoData,
    output logic [NUM_RW*DATA_WIDTH-1:0] opRwData,
    output logic [NUM_RW-1:0]            opWrStrobe,
    input  logic [NUM_IRQ-1:0]           ipIrqEvent,
    output logic                         opIrq
);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(8'h80);
    localparam logic [ADDR_WIDTH-1:0] A_EN   = ADDR_WIDTH'(8'h81);
    localparam logic [ADDR_WIDTH-1:0] A_PEND = ADDR_WIDTH'(8'h82);

    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_rdData;
    logic                  w_rdErr;
    logic [NUM_RW-1:0]     w_rwWe;
    logic [NUM_RW-1:0]     w_strobe;
    logic                  w_anyBe;
    logic                  w_enWe;
    logic                  w_stWe;
    logic [NUM_IRQ-1:0]    w_clr;
    logic [NUM_IRQ-1:0]    w_pend;

    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;
    logic                  r_rdError;
    logic [NUM_IRQ-1:0]    r_irqEn;
    logic [NUM_IRQ-1:0]    r_status;
    logic                  r_irq;

    always_comb begin
        w_mask = '0;
        for (int j = 0; j < DATA_WIDTH; j++)
            w_mask[j] = ipByteEnable[j/8];
    end

    assign w_anyBe = |ipByteEnable;
    assign w_enWe  = ipWrEnable && (ipAddress == A_EN);
    assign w_stWe  = ipWrEnable && (ipAddress == A_STAT);
    assign w_clr   = w_stWe ? (ipWrData[NUM_IRQ-1:0] & w_mask[NUM_IRQ-1:0]) : '0;
    assign w_pend  = r_status & r_irqEn;

    always_comb begin
        w_rwWe = '0;
        for (int i = 0; i < NUM_RW; i++)
            w_rwWe[i] = ipWrEnable && w_anyBe && (ipAddress == ADDR_WIDTH'(64 + i));
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RW; g++) begin : g_rw
            register_bank_rwreg #(
                .DATA_WIDTH (DATA_WIDTH),
                .RST_VAL    (RW_RESET[g*DATA_WIDTH +: DATA_WIDTH])
            ) u_reg (
                .ipClk    (ipClk),
                .Reset    (Reset),
                .ipWe     (w_rwWe[g]),
                .ipWrData (ipWrData),
                .ipMask   (w_mask),
                .opData   (opRwData[g*DATA_WIDTH +: DATA_WIDTH]),
                .opStrobe (w_strobe[g])
            );
        end
    endgenerate

    // Read mux works on pre-write state, so a same-cycle write or event is not seen.
    always_comb begin
        w_rdData = '0;
        w_rdErr  = 1'b1;
        for (int i = 0; i < NUM_RO; i++)
            if (ipAddress == ADDR_WIDTH'(i)) begin
                w_rdData = ipRoData[i*DATA_WIDTH +: DATA_WIDTH];
                w_rdErr  = 1'b0;
            end
        for (int i = 0; i < NUM_RW; i++)
            if (ipAddress == ADDR_WIDTH'(64 + i)) begin
                w_rdData = opRwData[i*DATA_WIDTH +: DATA_WIDTH];
                w_rdErr  = 1'b0;
            end
        if (ipAddress == A_STAT) begin
            w_rdData = DATA_WIDTH'(r_status);
            w_rdErr  = 1'b0;
        end
        if (ipAddress == A_EN) begin
            w_rdData = DATA_WIDTH'(r_irqEn);
            w_rdErr  = 1'b0;
        end
        if (ipAddress == A_PEND) begin
            w_rdData = DATA_WIDTH'(w_pend);
            w_rdErr  = 1'b0;
        end
    end

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_rdError <= 1'b0;
            r_irqEn   <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_rdValid <= ipRdEnable;
            r_rdError <= ipRdEnable & w_rdErr;
            r_rdData  <= ipRdEnable ? w_rdData : '0;
            if (w_enWe)
                r_irqEn <= (r_irqEn & ~w_mask[NUM_IRQ-1:0]) |
                           (ipWrData[NUM_IRQ-1:0] & w_mask[NUM_IRQ-1:0]);
            r_status  <= (r_status & ~w_clr) | ipIrqEvent;
            r_irq     <= |w_pend;
        end
    end

    // Pulse outputs are also masked by Reset so a response already in flight is dropped.
    assign opRdData   = r_rdData & {DATA_WIDTH{~Reset}};
    assign opRdValid  = r_rdValid & ~Reset;
    assign opRdError  = r_rdError & ~Reset;
    assign opWrStrobe = w_strobe & {NUM_RW{~Reset}};
    assign opIrq      = r_irq & ~Reset;
endmodule
